pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the processor fetch stage. Owns the PC register, the four-entry jump-target table that feeds absolute branch targets, and a start/halt run-control state machine. Each cycle it decides: hold, halt, branch to a table target, or increment. Instruction-memory address comes directly from `ProgCtr`.

## Interface
Parameters:
- `D`, 12: PC width in bits.
- `TW`, 8: jump-table entry width; entries are zero-extended to `D` (requires `TW <= D`).

Ports:
- `Clk` input 1: sole clock; all state updates on rising edge.
- `Reset` input 1: synchronous, active-high.
- `Start` input 1: begin program execution from address 0.
- `Stall` input 1: freeze PC this cycle.
- `HaltReq` input 1: decoded halt instruction.
- `BranchEn` input 1: decoded conditional-branch instruction.
- `Cond` input 1: branch condition from ALU flags.
- `JumpIdx` input 2: table index of branch target.
- `JtWrEn` input 1: jump-table write enable.
- `JtWrIdx` input 2: table entry to write.
- `JtWrData` input TW: value to write.
- `ProgCtr` output D: current PC, registered.
- `Running` output 1: high while in RUN.
- `Done` output 1: high while in HALT.

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE, `ProgCtr`=0, all four table entries=0, `Running`=0, `Done`=0.
- IDLE: `ProgCtr` held at 0. `Start`=1 → RUN, `ProgCtr` stays 0. All other control inputs ignored.
- RUN, per cycle, first match wins:
  - `Stall`=1: hold PC and state; `HaltReq`/`BranchEn` ignored that cycle.
  - `HaltReq`=1: → HALT, PC held.
  - `BranchEn`=1 and `Cond`=1: PC ← zero-extend(table[`JumpIdx`]).
  - otherwise: PC ← PC+1 modulo 2^D (all-ones wraps to 0).
  - `BranchEn`=1 with `Cond`=0 increments normally.
  - `Start` ignored in RUN.
- HALT: PC held, `Done`=1. `Start`=1 → RUN with PC ← 0, `Done` clears. `Stall`, `HaltReq`, `BranchEn` ignored.
- Jump table: four TW-bit registers. Writes occur in any state, including during `Stall`, when `JtWrEn`=1.
- Same-cycle write and branch to the same index: the branch uses the pre-write (old) value; the new value is visible from the next cycle.
- `Running` = (state==RUN); `Done` = (state==HALT); both are state-decoded, never asserted together.
- `Reset` overrides everything, including a same-cycle `Start` or write, and returns PC, table and state to reset values from any state.

## Timing
- All outputs are registered or state-decoded; no combinational path from inputs to outputs.
- Decision latency 1 cycle: inputs sampled at edge N; the new `ProgCtr`, `Running` and `Done` are visible after edge N.
- `Start` in IDLE at edge N: `Running`=1 after N. First increment at edge N+1 if not stalled.
- `HaltReq` at edge N: `Done`=1 and `Running`=0 after N. PC keeps the halt-instruction address.
- Table write at edge N: available to a branch sampled at edge N+1.
- No handshake beyond level sampling; `Start` may be held multiple cycles. It causes exactly one transition per eligible state.

## Test plan
- Reset then `Start` for 1 cycle, no branches, 5 free cycles → `ProgCtr` sequence 0,1,2,3,4,5; `Running`=1, `Done`=0.
- Write table[2]=0xA5, then `BranchEn`=1, `Cond`=1, `JumpIdx`=2 → next `ProgCtr`=0x0A5. Repeat with `Cond`=0 → PC+1.
- Same cycle: `JtWrEn`=1, `JtWrIdx`=1, `JtWrData`=0x40 (old value 0x10) and a taken branch with `JumpIdx`=1 → PC=0x010. A subsequent taken branch on index 1 → PC=0x040.
- `Stall`=1 with `HaltReq`=1 at PC=7 → PC stays 7 in RUN. Drop `Stall` → `Done`=1, PC=7. `Start` → PC=0, `Running`=1.
- Force PC to 0xFFF via table entry 0xFF plus increments (set D=8 variant or run to wrap) → next PC=0.
- `Reset` asserted mid-RUN at PC=0x23 with table nonzero → `ProgCtr`=0, state IDLE, `Running`=0. A taken branch on any index afterwards yields 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with a 4-entry jump-target table and run control.
// Ports: Clk/Reset (sync, active-high); Start, Stall, HaltReq, BranchEn, Cond, JumpIdx decide PC;
//        JtWrEn/JtWrIdx/JtWrData load the table; ProgCtr, Running, Done are registered outputs.
module pc_sequencer #(
   parameter int D  = 12,  // PC width; TW must not exceed D
   parameter int TW = 8    // jump-table entry width
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Stall,
   input  logic          HaltReq,
   input  logic          BranchEn,
   input  logic          Cond,
   input  logic [1:0]    JumpIdx,
   input  logic          JtWrEn,
   input  logic [1:0]    JtWrIdx,
   input  logic [TW-1:0] JtWrData,
   output logic [D-1:0]  ProgCtr,
   output logic          Running,
   output logic          Done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [D-1:0]    pc_q, pc_d;
   logic [D-1:0]    branch_tgt;
   logic [TW-1:0]   jt_q [4];
   logic            running_q, done_q;

   // Next-state and next-PC decision. The branch target is read from the
   // registered table, so a same-cycle write to the same index is not seen
   // until the following cycle.
   always_comb begin
      branch_tgt = '0;
      branch_tgt[TW-1:0] = jt_q[JumpIdx];
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         S_IDLE: begin
            pc_d = '0;
            if (Start) state_d = S_RUN;
         end
         S_RUN: begin
            if (Stall) begin
               // hold everything
            end else if (HaltReq) begin
               state_d = S_HALT;  // PC keeps the halt-instruction address
            end else if (BranchEn && Cond) begin
               pc_d = branch_tgt;
            end else begin
               pc_d = pc_q + D'(1);  // wraps modulo 2^D
            end
         end
         S_HALT: begin
            if (Start) begin
               state_d = S_RUN;
               pc_d    = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = '0;
         end
      endcase
   end

   // Status flags are registered from the next state so they line up with
   // the state register without any input-to-output combinational path.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < 4; i++) jt_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         running_q <= (state_d == S_RUN);
         done_q    <= (state_d == S_HALT);
         if (JtWrEn) jt_q[JtWrIdx] <= JtWrData;  // allowed in every state, even while stalled
      end
   end

   assign ProgCtr = pc_q;
   assign Running = running_q;
   assign Done    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam int D  = 12;
   localparam int TW = 8;

   logic          Clk = 1'b0;
   logic          Reset, Start, Stall, HaltReq, BranchEn, Cond, JtWrEn;
   logic [1:0]    JumpIdx, JtWrIdx;
   logic [TW-1:0] JtWrData;
   logic [D-1:0]  ProgCtr;
   logic          Running, Done;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(.D(D), .TW(TW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .HaltReq(HaltReq),
      .BranchEn(BranchEn), .Cond(Cond), .JumpIdx(JumpIdx), .JtWrEn(JtWrEn),
      .JtWrIdx(JtWrIdx), .JtWrData(JtWrData), .ProgCtr(ProgCtr),
      .Running(Running), .Done(Done)
   );

   always #5 Clk = ~Clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr_inputs();
      Reset = 0; Start = 0; Stall = 0; HaltReq = 0; BranchEn = 0; Cond = 0;
      JumpIdx = 0; JtWrEn = 0; JtWrIdx = 0; JtWrData = '0;
   endtask

   task automatic test_reset();
      clr_inputs();
      Reset = 1;
      tick(); tick();
      checks++;
      if (ProgCtr !== 12'h000 || Running !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: pc=%h run=%b done=%b, want pc=000 run=0 done=0", ProgCtr, Running, Done);
      end
      Reset = 0;
      // IDLE ignores everything but Start
      BranchEn = 1; Cond = 1; HaltReq = 1; Stall = 1;
      tick();
      checks++;
      if (ProgCtr !== 12'h000 || Running !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore: pc=%h run=%b done=%b, want pc=000 run=0 done=0", ProgCtr, Running, Done);
      end
      clr_inputs();
   endtask

   task automatic test_count();
      Start = 1;
      tick();
      Start = 0;
      checks++;
      if (ProgCtr !== 12'h000 || Running !== 1'b1 || Done !== 1'b0) begin
         errors++;
         $display("FAIL start: pc=%h run=%b done=%b, want pc=000 run=1 done=0", ProgCtr, Running, Done);
      end
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (ProgCtr !== 12'(i) || Running !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL count_%0d: pc=%h run=%b done=%b, want pc=%h run=1 done=0", i, ProgCtr, Running, Done, 12'(i));
         end
      end
   endtask

   task automatic test_branch();
      // PC is 5; write table[2]=A5 while incrementing
      JtWrEn = 1; JtWrIdx = 2; JtWrData = 8'hA5;
      tick();
      JtWrEn = 0;
      checks++;
      if (ProgCtr !== 12'h006) begin
         errors++;
         $display("FAIL write_incr: pc=%h, want 006", ProgCtr);
      end
      BranchEn = 1; Cond = 1; JumpIdx = 2;
      tick();
      checks++;
      if (ProgCtr !== 12'h0A5) begin
         errors++;
         $display("FAIL branch_taken: pc=%h, want 0a5", ProgCtr);
      end
      Cond = 0;
      tick();
      checks++;
      if (ProgCtr !== 12'h0A6) begin
         errors++;
         $display("FAIL branch_not_taken: pc=%h, want 0a6", ProgCtr);
      end
      clr_inputs();
   endtask

   task automatic test_same_cycle_write();
      JtWrEn = 1; JtWrIdx = 1; JtWrData = 8'h10;
      tick();  // pc 0a7
      JtWrData = 8'h40;
      BranchEn = 1; Cond = 1; JumpIdx = 1;
      tick();
      JtWrEn = 0;
      checks++;
      if (ProgCtr !== 12'h010) begin
         errors++;
         $display("FAIL wr_branch_old: pc=%h, want 010", ProgCtr);
      end
      tick();
      checks++;
      if (ProgCtr !== 12'h040) begin
         errors++;
         $display("FAIL wr_branch_new: pc=%h, want 040", ProgCtr);
      end
      clr_inputs();
   endtask

   task automatic test_stall_halt();
      // table write during stall; PC holds at 040
      Stall = 1; JtWrEn = 1; JtWrIdx = 3; JtWrData = 8'h07;
      tick();
      JtWrEn = 0; Stall = 0;
      checks++;
      if (ProgCtr !== 12'h040 || Running !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold: pc=%h run=%b, want pc=040 run=1", ProgCtr, Running);
      end
      BranchEn = 1; Cond = 1; JumpIdx = 3;
      tick();
      checks++;
      if (ProgCtr !== 12'h007) begin
         errors++;
         $display("FAIL stall_write_branch: pc=%h, want 007", ProgCtr);
      end
      // stall beats halt and branch
      Stall = 1; HaltReq = 1;
      tick();
      checks++;
      if (ProgCtr !== 12'h007 || Running !== 1'b1 || Done !== 1'b0) begin
         errors++;
         $display("FAIL stall_over_halt: pc=%h run=%b done=%b, want pc=007 run=1 done=0", ProgCtr, Running, Done);
      end
      Stall = 0;
      tick();
      checks++;
      if (ProgCtr !== 12'h007 || Running !== 1'b0 || Done !== 1'b1) begin
         errors++;
         $display("FAIL halt: pc=%h run=%b done=%b, want pc=007 run=0 done=1", ProgCtr, Running, Done);
      end
      HaltReq = 0; // BranchEn/Cond still high: ignored in HALT
      tick();
      checks++;
      if (ProgCtr !== 12'h007 || Done !== 1'b1) begin
         errors++;
         $display("FAIL halt_hold: pc=%h done=%b, want pc=007 done=1", ProgCtr, Done);
      end
      clr_inputs();
      Start = 1;
      tick();
      checks++;
      if (ProgCtr !== 12'h000 || Running !== 1'b1 || Done !== 1'b0) begin
         errors++;
         $display("FAIL restart: pc=%h run=%b done=%b, want pc=000 run=1 done=0", ProgCtr, Running, Done);
      end
      // Start held in RUN is ignored
      tick();
      Start = 0;
      checks++;
      if (ProgCtr !== 12'h001 || Running !== 1'b1) begin
         errors++;
         $display("FAIL start_in_run: pc=%h run=%b, want pc=001 run=1", ProgCtr, Running);
      end
   endtask

   task automatic test_wrap();
      JtWrEn = 1; JtWrIdx = 0; JtWrData = 8'hFF;
      tick();  // pc 002
      JtWrEn = 0;
      BranchEn = 1; Cond = 1; JumpIdx = 0;
      tick();
      clr_inputs();
      checks++;
      if (ProgCtr !== 12'h0FF) begin
         errors++;
         $display("FAIL wrap_branch: pc=%h, want 0ff", ProgCtr);
      end
      for (int i = 0; i < 12'hFFF - 12'h0FF; i++) tick();
      checks++;
      if (ProgCtr !== 12'hFFF || Running !== 1'b1) begin
         errors++;
         $display("FAIL wrap_top: pc=%h run=%b, want pc=fff run=1", ProgCtr, Running);
      end
      tick();
      checks++;
      if (ProgCtr !== 12'h000) begin
         errors++;
         $display("FAIL wrap_zero: pc=%h, want 000", ProgCtr);
      end
   endtask

   task automatic test_reset_mid_run();
      JtWrEn = 1; JtWrIdx = 1; JtWrData = 8'h23;
      tick();  // pc 001
      JtWrEn = 0;
      BranchEn = 1; Cond = 1; JumpIdx = 1;
      tick();
      clr_inputs();
      checks++;
      if (ProgCtr !== 12'h023) begin
         errors++;
         $display("FAIL pre_reset_pc: pc=%h, want 023", ProgCtr);
      end
      // reset wins over same-cycle Start and table write
      Reset = 1; Start = 1; JtWrEn = 1; JtWrIdx = 2; JtWrData = 8'h55;
      tick();
      clr_inputs();
      checks++;
      if (ProgCtr !== 12'h000 || Running !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: pc=%h run=%b done=%b, want pc=000 run=0 done=0", ProgCtr, Running, Done);
      end
      tick();
      checks++;
      if (Running !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: run=%b, want 0", Running);
      end
      Start = 1;
      tick();
      Start = 0;
      for (int k = 0; k < 4; k++) begin
         BranchEn = 1; Cond = 1; JumpIdx = 2'(k);
         tick();
         checks++;
         if (ProgCtr !== 12'h000) begin
            errors++;
            $display("FAIL cleared_table_%0d: pc=%h, want 000", k, ProgCtr);
         end
      end
      clr_inputs();
   endtask

   initial begin
      clr_inputs();
      test_reset();
      test_count();
      test_branch();
      test_same_cycle_write();
      test_stall_halt();
      test_wrap();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
